fma_operand_queue: RTL
======================

Name: fma_operand_queue

Overview:
Next-generation operand staging for the FMA array.
- Assembles one "a b c" operand set per FMA from sparse per-operand writes issued by the data cache. Operands for one set may arrive across any number of cycles.
- Each completed set is pushed into a DEPTH-entry FIFO.
- The FMA array drains the FIFO with a valid/ready handshake, so cache fetch and FMA consumption are decoupled and both sides can stall.

Parameters:
- FMA_COUNT, 2, number of FMA lanes served per set.
- WIDTH, 16, bits per operand.
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset; synchronous, active-high.
- abc_in  in  FMA_COUNT*3*WIDTH  operands; lane k occupies bits [k*3W +: 3W]; within a lane a = [0 +: W], b = [W +: W], c = [2W +: W].
- abc_valid_in  in  FMA_COUNT*3  per-operand write strobes; lane k: bit 3k = a, bit 3k+1 = b, bit 3k+2 = c.
- flush_in  in  1  discard all queued and staged data.
- fill_ready_out  out  1  high when the block accepts abc_valid_in this cycle.
- abc_out  out  FMA_COUNT*3*WIDTH  FIFO head operand set.
- c_valid_out  out  FMA_COUNT  FIFO head per-lane c-overwrite flags.
- abc_valid_out  out  1  FIFO head is valid.
- abc_ready_in  in  1  FMA array consumes the head.
- count_out  out  $clog2(DEPTH+1)  number of FIFO entries.

Behaviour:
- Staging registers: abc_stage, plus per-lane a_seen, b_seen and c_seen masks.
- Operand accept:
  - Accept happens on a cycle with fill_ready_out = 1.
  - Each asserted strobe writes its W-bit field into abc_stage and sets the matching seen bit.
  - A repeated write to the same field before commit overwrites it (last write wins).
  - a and b may arrive in different cycles.
- stage_complete = (a_seen & b_seen) all ones. It is evaluated on registered masks only.
- Commit:
  - Condition: stage_complete and (count < DEPTH, or a pop occurs in the same cycle).
  - Action: push {abc_stage, c_seen} into the FIFO, then clear all staging to 0.
  - Strobes accepted in the commit cycle are written into the freshly cleared staging, so they belong to the next set.
- Latency: when the last a/b strobe is accepted in cycle t and the FIFO was empty, abc_valid_out = 1 in cycle t+2.
- fill_ready_out = !(stage_complete && count == DEPTH). It is registered-state only, with no combinational path from abc_ready_in.
  - While it is low, all strobes are ignored.
  - A pop in that cycle still lets the staged set commit at the same edge.
- FIFO outputs:
  - Pop = abc_valid_out && abc_ready_in.
  - abc_valid_out = (count != 0).
  - abc_out and c_valid_out show the head entry directly.
  - Entries leave in commit order.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- c semantics:
  - c_valid_out[k] = 1 only if lane k received a c strobe for that set; otherwise the FMA keeps its old c.
  - A c field that was never written reads 0.
- flush_in:
  - Takes effect at the next edge.
  - Clears FIFO pointers, count, staging and masks.
  - Overrides commit, pop and accept in the same cycle.
  - abc_valid_out = 0 on the following cycle.
- Reset (rst_in, at any time including mid-set or mid-drain) clears everything:
  - abc_out = 0, c_valid_out = 0, abc_valid_out = 0, count_out = 0;
  - fill_ready_out = 1.
- Protocol: abc_out and c_valid_out must stay stable while abc_valid_out = 1 and abc_ready_in = 0.

Test Plan:
- Single set (FMA_COUNT=2, W=16, DEPTH=2), abc_ready_in=1: cycle 0, abc_valid_in=6'b011011 with a0=3, b0=4, a1=5, b1=6 -> cycle 2: abc_valid_out=1 for exactly one cycle, a0=3, b0=4, a1=5, b1=6, c fields 0, c_valid_out=2'b00.
- Split arrival:
  - cycle 0: a0=2;
  - cycle 1: b0=8;
  - cycle 3: a1=1, b1=1, c1=7;
  - -> cycle 5: head a0=2, b0=8, c1=7, c_valid_out=2'b10; count_out returns to 0 after the pop.
- Backpressure, abc_ready_in=0, three complete sets S1..S3 -> count_out=2, S3 held in staging, fill_ready_out=0. A strobe a0=99 presented while stalled is ignored. Raising abc_ready_in drains S1, S2, S3 in order with unchanged values.
- Last write wins: a0=1 in cycle 0, a0=9 in cycle 1, b0, a1, b1 in cycle 2 -> committed entry has a0=9.
- Flush while count_out=1 and lane 0 partially staged -> next cycle: count_out=0, abc_valid_out=0, fill_ready_out=1. A following single complete set emerges alone with no stale fields.
- rst_in asserted for 1 cycle with count_out=2 -> next cycle all outputs 0, fill_ready_out=1. The normal single-set sequence then passes.

Source files
------------

// File: rtl/fma_operand_queue.sv
// fma_operand_queue: stages sparse a/b/c operand writes into complete FMA sets and queues them
module fma_operand_queue #(
  parameter int FMA_COUNT = 2,
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [FMA_COUNT*3*WIDTH-1:0]         abc_in,
  input  logic [FMA_COUNT*3-1:0]               abc_valid_in,
  input  logic                                 flush_in,
  output logic                                 fill_ready_out,
  output logic [FMA_COUNT*3*WIDTH-1:0]         abc_out,
  output logic [FMA_COUNT-1:0]                 c_valid_out,
  output logic                                 abc_valid_out,
  input  logic                                 abc_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]           count_out
);
  localparam int TW = FMA_COUNT * 3 * WIDTH;
  localparam int EW = TW + FMA_COUNT;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [TW-1:0]        r_stage, w_stage_nxt;
  logic [FMA_COUNT-1:0] r_a_seen, r_b_seen, r_c_seen, w_a_nxt, w_b_nxt, w_c_nxt;
  logic [EW-1:0]        r_mem [DEPTH];
  logic [PW-1:0]        r_rd, r_wr;
  logic [CW-1:0]        r_count;
  logic                 w_complete, w_pop, w_commit, w_fill_ready;
  logic [EW-1:0]        w_head;
  assign w_complete = &(r_a_seen & r_b_seen);
  assign w_pop = (r_count != '0) && abc_ready_in;
  assign w_commit = w_complete && ((r_count < CW'(DEPTH)) || w_pop);
  assign w_fill_ready = !(w_complete && (r_count == CW'(DEPTH)));
  assign w_head = r_mem[r_rd];
  assign fill_ready_out = w_fill_ready;
  assign abc_valid_out = r_count != '0;
  assign abc_out = abc_valid_out ? w_head[EW-1:FMA_COUNT] : '0;
  assign c_valid_out = abc_valid_out ? w_head[FMA_COUNT-1:0] : '0;
  assign count_out = r_count;
  // a commit clears staging first, so strobes from the same cycle start the next set
  always_comb begin
    w_stage_nxt = w_commit ? '0 : r_stage;
    w_a_nxt = w_commit ? '0 : r_a_seen;
    w_b_nxt = w_commit ? '0 : r_b_seen;
    w_c_nxt = w_commit ? '0 : r_c_seen;
    for (int k = 0; k < FMA_COUNT; k++) begin
      for (int j = 0; j < 3; j++)
        if (w_fill_ready && abc_valid_in[3*k+j])
          w_stage_nxt[(3*k+j)*WIDTH +: WIDTH] = abc_in[(3*k+j)*WIDTH +: WIDTH];
      w_a_nxt[k] = w_a_nxt[k] | (w_fill_ready & abc_valid_in[3*k]);
      w_b_nxt[k] = w_b_nxt[k] | (w_fill_ready & abc_valid_in[3*k+1]);
      w_c_nxt[k] = w_c_nxt[k] | (w_fill_ready & abc_valid_in[3*k+2]);
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      r_stage <= '0;
      r_a_seen <= '0;
      r_b_seen <= '0;
      r_c_seen <= '0;
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      r_stage <= w_stage_nxt;
      r_a_seen <= w_a_nxt;
      r_b_seen <= w_b_nxt;
      r_c_seen <= w_c_nxt;
      r_rd <= r_rd + PW'(w_pop);
      r_wr <= r_wr + PW'(w_commit);
      r_count <= r_count + CW'(w_commit) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk_in)
    if (w_commit && !rst_in && !flush_in) r_mem[r_wr] <= {r_stage, r_c_seen};
endmodule
